// File: rtl/seq_pattern_detector_if.sv
// Serial-bit detector bus: sampled input side plus match pulse, count and fill status.
// Pure wiring; no timing or flow control of its own.
interface seq_pattern_detector_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             A;
    logic             clr_count;
    logic             Y;
    logic [CNT_W-1:0] match_count;
    logic [3:0]       fill;

    modport master (
        output en, A, clr_count,
        input  Y, match_count, fill
    );

    modport slave (
        input  en, A, clr_count,
        output Y, match_count, fill
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with optional overlap and a saturating match counter.
// Y pulses on the same edge that samples the completing bit; en=0 freezes state (no backpressure).
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 2,
    parameter logic [PAT_LEN-1:0] PATTERN = 2'b01,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_pattern_detector_if.slave   bus
);
    localparam logic [3:0] FILL_FULL = 4'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [3:0]         fill_q, fill_d;
    logic               y_q, y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_LEN-1:0] hist_shift;
    logic [3:0]         fill_inc;
    logic               match;

    always_comb begin
        hist_shift = {hist_q[PAT_LEN-2:0], bus.A};
        fill_inc   = (fill_q >= FILL_FULL) ? FILL_FULL : fill_q + 4'd1;
        match      = bus.en && (fill_inc == FILL_FULL) && (hist_shift == PATTERN);

        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.en) begin
            hist_d = hist_shift;
            // Non-overlapping mode forgets the history by emptying fill.
            fill_d = (match && !OVERLAP) ? 4'd0 : fill_inc;
        end

        y_d = match;

        cnt_d = cnt_q;
        if (bus.clr_count) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.Y           = y_q;
    assign bus.match_count = cnt_q;
    assign bus.fill        = fill_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed-vector bench for seq_pattern_detector across four parameter sets.
module tb_seq_pattern_detector;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    seq_pattern_detector_if #(.CNT_W(8)) bus0 ();
    seq_pattern_detector_if #(.CNT_W(8)) bus1 ();
    seq_pattern_detector_if #(.CNT_W(8)) bus2 ();
    seq_pattern_detector_if #(.CNT_W(2)) bus3 ();

    seq_pattern_detector #(.PAT_LEN(2), .PATTERN(2'b01), .OVERLAP(1'b1), .CNT_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_pattern_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    seq_pattern_detector #(.PAT_LEN(2), .PATTERN(2'b01), .OVERLAP(1'b1), .CNT_W(2))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct {
        int   dut;
        logic en;
        logic a;
        logic clr;
        logic y;
        int   cnt;
        int   fill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic en, input logic a, input logic clr);
        bus0.en = (d == 0) ? en : 1'b0;  bus0.A = a;  bus0.clr_count = (d == 0) ? clr : 1'b0;
        bus1.en = (d == 1) ? en : 1'b0;  bus1.A = a;  bus1.clr_count = (d == 1) ? clr : 1'b0;
        bus2.en = (d == 2) ? en : 1'b0;  bus2.A = a;  bus2.clr_count = (d == 2) ? clr : 1'b0;
        bus3.en = (d == 3) ? en : 1'b0;  bus3.A = a;  bus3.clr_count = (d == 3) ? clr : 1'b0;
    endtask

    task automatic sample(input int d, output int y, output int cnt, output int fill);
        case (d)
            0:       begin y = int'(bus0.Y); cnt = int'(bus0.match_count); fill = int'(bus0.fill); end
            1:       begin y = int'(bus1.Y); cnt = int'(bus1.match_count); fill = int'(bus1.fill); end
            2:       begin y = int'(bus2.Y); cnt = int'(bus2.match_count); fill = int'(bus2.fill); end
            default: begin y = int'(bus3.Y); cnt = int'(bus3.match_count); fill = int'(bus3.fill); end
        endcase
    endtask

    task automatic step(input int d, input logic en, input logic a, input logic clr);
        @(negedge clk);
        drive(d, en, a, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int d, input int ey, input int ec, input int ef);
        int y, c, f;
        sample(d, y, c, f);
        check({tag, ".Y"},     y, ey);
        check({tag, ".count"}, c, ec);
        check({tag, ".fill"},  f, ef);
    endtask

    initial begin
        // dut0: basic match, overlap, enable gap and clear
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2});
        vecs.push_back('{0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2});
        vecs.push_back('{0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2});
        vecs.push_back('{0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2});
        vecs.push_back('{0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2});
        vecs.push_back('{0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2});
        // dut1: 101 with overlap
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 3});
        vecs.push_back('{1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3});
        vecs.push_back('{1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 3});
        // dut2: 101 without overlap
        vecs.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2});
        vecs.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0});
        vecs.push_back('{2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{2, 1'b1, 1'b1, 1'b0, 1'b0, 1, 2});
        // dut3: 2-bit counter saturation, then clear racing a match
        vecs.push_back('{3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{3, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2});
        vecs.push_back('{3, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2});
        vecs.push_back('{3, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2});
        vecs.push_back('{3, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2});
        vecs.push_back('{3, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2});
        vecs.push_back('{3, 1'b1, 1'b0, 1'b0, 1'b0, 3, 2});
        vecs.push_back('{3, 1'b1, 1'b1, 1'b0, 1'b1, 3, 2});
        vecs.push_back('{3, 1'b1, 1'b0, 1'b0, 1'b0, 3, 2});
        vecs.push_back('{3, 1'b1, 1'b1, 1'b1, 1'b1, 0, 2});

        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            expect3($sformatf("reset.dut%0d", d), d, 0, 0, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].dut, vecs[i].en, vecs[i].a, vecs[i].clr);
            expect3($sformatf("vec%0d.dut%0d", i, vecs[i].dut), vecs[i].dut,
                    int'(vecs[i].y), vecs[i].cnt, vecs[i].fill);
        end

        // Async reset mid-cycle while Y is high, then history must not survive it
        step(0, 1'b1, 1'b0, 1'b0);
        expect3("pre_rst_a0", 0, 0, 1, 2);
        step(0, 1'b1, 1'b1, 1'b0);
        expect3("pre_rst_a1", 0, 1, 2, 2);
        #1;
        rst = 1'b0;
        #1;
        expect3("async_rst", 0, 0, 0, 0);
        step(0, 1'b1, 1'b0, 1'b0);
        expect3("in_rst_edge", 0, 0, 0, 0);
        #1;
        rst = 1'b1;
        step(0, 1'b1, 1'b1, 1'b0);
        expect3("post_rst_a1", 0, 0, 0, 1);
        step(0, 1'b1, 1'b1, 1'b0);
        expect3("post_rst_a11", 0, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
